// File: rtl/z80_trace_pkg.sv
// Shared types for the Z80 bus tracer: cycle type codes, the trace record layout
// and the default record queue depth.
package z80_trace_pkg;

   localparam int unsigned DefaultDepth = 8;

   typedef enum logic [2:0] {
      TypeFetch  = 3'd0,
      TypeMemRd  = 3'd1,
      TypeMemWr  = 3'd2,
      TypeIoRd   = 3'd3,
      TypeIoWr   = 3'd4,
      TypeIntAck = 3'd5
   } cyc_type_e;

   typedef struct packed {
      cyc_type_e   typ;
      logic [15:0] addr;
      logic [7:0]  data;
      logic [15:0] ts;
   } trace_rec_t;

   localparam int unsigned RecWidth = $bits(trace_rec_t);

   // Write cycles carry CPU-driven data; everything else captures the read bus.
   function automatic logic reads_di(cyc_type_e t);
      return (t != TypeMemWr) && (t != TypeIoWr);
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic power-of-two FIFO with valid/ready on both sides; a write is accepted when
// full only if a pop happens on the same edge.
module trace_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   input  logic [Width-1:0] wr_data_i,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic [Width-1:0] rd_data_o
);

   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

   logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
   logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
   logic [Width-1:0] mem_q [Depth];
   logic             empty, full, wr_fire, rd_fire;

   // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                  (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

   assign rd_valid_o = !empty;
   assign rd_fire    = rd_valid_o && rd_ready_i;
   assign wr_ready_o = !full || rd_ready_i;
   assign wr_fire    = wr_valid_i && wr_ready_o;
   assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
      end
   end

endmodule

// File: rtl/z80_bus_tracer.sv
// Z80 (tv80s) bus cycle tracer: classifies sampled strobes into typed cycles, stamps
// each finished cycle with a free-running counter and queues it for a consumer.
module z80_bus_tracer
   import z80_trace_pkg::*;
#(
   parameter int unsigned DEPTH = DefaultDepth
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        rfsh_n,
   input  logic [15:0] A,
   input  logic [7:0]  di,
   input  logic [7:0]  dout,
   output logic        rec_valid,
   input  logic        rec_ready,
   output logic [2:0]  rec_type,
   output logic [15:0] rec_addr,
   output logic [7:0]  rec_data,
   output logic [15:0] rec_time,
   output logic        overflow,
   output logic [7:0]  drop_cnt
);

   logic        cur_act;
   cyc_type_e   cur_type;

   logic        act_q, act_d;
   cyc_type_e   type_q, type_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        keep_q, keep_d;
   logic        end_cyc;

   logic        push_q, push_d;
   trace_rec_t  push_rec_q, push_rec_d;

   logic [15:0] ts_q, ts_d;
   logic        overflow_q, overflow_d;
   logic [7:0]  drop_q, drop_d;

   logic        fifo_wr_ready;
   logic [RecWidth-1:0] fifo_rd_data;
   trace_rec_t  rd_rec;
   logic        drop;

   // Refresh edges are invisible: they neither classify nor end a cycle.
   always_comb begin
      cur_act  = 1'b0;
      cur_type = TypeFetch;
      if (rfsh_n) begin
         if (!m1_n && !iorq_n) begin
            cur_act  = 1'b1;
            cur_type = TypeIntAck;
         end else if (!m1_n && !mreq_n && !rd_n) begin
            cur_act  = 1'b1;
            cur_type = TypeFetch;
         end else if (!mreq_n && !rd_n) begin
            cur_act  = 1'b1;
            cur_type = TypeMemRd;
         end else if (!mreq_n && !wr_n) begin
            cur_act  = 1'b1;
            cur_type = TypeMemWr;
         end else if (!iorq_n && !rd_n) begin
            cur_act  = 1'b1;
            cur_type = TypeIoRd;
         end else if (!iorq_n && !wr_n) begin
            cur_act  = 1'b1;
            cur_type = TypeIoWr;
         end
      end
   end

   always_comb begin
      act_d   = act_q;
      type_d  = type_q;
      addr_d  = addr_q;
      data_d  = data_q;
      keep_d  = keep_q;
      end_cyc = 1'b0;
      if (rfsh_n) begin
         end_cyc = act_q && (!cur_act || (cur_type != type_q));
         if (cur_act) begin
            if (!act_q || (cur_type != type_q)) begin
               type_d = cur_type;
               keep_d = en;
            end
            addr_d = A;
            data_d = reads_di(cur_type) ? di : dout;
         end
         act_d = cur_act;
      end

      push_d     = end_cyc && keep_q;
      push_rec_d = push_rec_q;
      if (end_cyc) begin
         push_rec_d.typ  = type_q;
         push_rec_d.addr = addr_q;
         push_rec_d.data = data_q;
         push_rec_d.ts   = ts_q;
      end
   end

   assign drop = push_q && !fifo_wr_ready;

   always_comb begin
      ts_d       = ts_q + 16'd1;
      overflow_d = overflow_q || drop;
      drop_d     = drop_q;
      if (drop && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_q      <= 1'b0;
         type_q     <= TypeFetch;
         addr_q     <= '0;
         data_q     <= '0;
         keep_q     <= 1'b0;
         push_q     <= 1'b0;
         push_rec_q <= '0;
         ts_q       <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         act_q      <= act_d;
         type_q     <= type_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         keep_q     <= keep_d;
         push_q     <= push_d;
         push_rec_q <= push_rec_d;
         ts_q       <= ts_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   trace_fifo #(
      .Width (RecWidth),
      .Depth (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .wr_valid_i (push_q),
      .wr_ready_o (fifo_wr_ready),
      .wr_data_i  (push_rec_q),
      .rd_valid_o (rec_valid),
      .rd_ready_i (rec_ready),
      .rd_data_o  (fifo_rd_data)
   );

   assign rd_rec   = trace_rec_t'(fifo_rd_data);
   assign rec_type = rd_rec.typ;
   assign rec_addr = rd_rec.addr;
   assign rec_data = rd_rec.data;
   assign rec_time = rd_rec.ts;
   assign overflow = overflow_q;
   assign drop_cnt = drop_q;

endmodule
